pcie_tx_lane_striper: RTL and testbench
=======================================

// Module: pcie_tx_lane_striper
// PURPOSE
//  Parametrised TX byte striper between Data Link Layer frames and per-lane encoders. Replaces the always-ready
//  single-byte feed of the PHY top. Buffers MAC frames with valid/ready backpressure and stripes bytes across the
//  active lanes (x1..xNUM_LANES). Inserts SKP ordered sets on all active lanes every SKP_INTERVAL symbol times.
// PARAMETERS
//  MAC_FRAME_WIDTH  32    input frame width, multiple of 8; B = MAC_FRAME_WIDTH/8 bytes per frame
//  NUM_LANES        4     physical lanes, power of 2, >=1
//  SKP_INTERVAL     1180  symbol times (output cycles) between SKP ordered sets, >= SKP_LEN+1
//  SKP_LEN          4     symbols per lane per SKP OS: 1 COM + (SKP_LEN-1) SKP
// PORTS
//  clk_i              in   1                  symbol clock
//  rst_ni             in   1                  synchronous reset, active low
//  tx_enable_i        in   1                  link TX enable from controller
//  active_lanes_i     in   NUM_LANES          thermometer lane mask (1,3,F,...), sampled on tx_enable_i rise
//  mac_data_frame_i   in   MAC_FRAME_WIDTH    frame; byte 0 = bits [7:0], sent first
//  mac_is_k_i         in   B                  per-byte K-symbol flag
//  mac_data_valid_i   in   1                  frame valid
//  mac_data_ready_o   out  1                  frame accept; transfer on valid & ready
//  lane_data_o        out  NUM_LANES*8        lane n symbol at [8n+7:8n]
//  lane_is_k_o        out  NUM_LANES          lane n K flag
//  lane_valid_o       out  1                  symbols valid this cycle
//  skp_active_o       out  1                  SKP OS being sent this cycle
// BEHAVIOUR
//  - Reset (rst_ni=0 at an edge): all outputs 0, buffer count 0, SKP counter 0, state IDLE, lane mask = x1.
//    Applies mid-operation too: buffered bytes are discarded and never emitted.
//  - A = active lane count. Mask latched in IDLE when tx_enable_i rises. Zero or non-thermometer mask -> x1.
//  - FSM: IDLE -> RUN on tx_enable_i=1. RUN -> SKP when SKP counter = SKP_INTERVAL-1. SKP -> RUN after SKP_LEN
//    cycles. Any state -> IDLE on tx_enable_i=0; this flushes the buffer.
//  - Byte FIFO, depth D = 2*max(B,NUM_LANES); count width clog2(D+1); wrap-around read/write pointers mod D.
//  - mac_data_ready_o = (state != IDLE) && (D - count >= B). Registered-state based only, no path from valid.
//  - Drain (RUN only): when count >= A, pop A bytes; FIFO byte i goes to lane i, K flag follows its byte.
//    count_next = count + B*accept - A*drain. Accept and drain in the same cycle are legal.
//  - Underflow (RUN, count < A): every active lane sends logical idle 8'h00, k=0. No partial stripes.
//  - SKP state: cycle 0 = 8'hBC k=1 (COM); remaining cycles = 8'h1C k=1 (SKP), on every active lane.
//    skp_active_o=1. No drain. Accept continues while space remains. SKP counter clears on SKP entry.
//  - SKP counter increments each RUN cycle, holds in SKP, clears in IDLE. A pending SKP preempts data.
//  - Inactive lanes always 8'h00, k=0. lane_valid_o=1 in RUN and SKP, 0 in IDLE.
//  - Outputs registered. Frame accepted at edge k into an empty FIFO appears on lanes after edge k+1 if A <= B.
//  - Byte order across frames, stripes and SKP insertion is strictly preserved. No byte dropped or duplicated.
// TESTING
//  1 x4, B=4: frames 0x03020100, 0x07060504 back-to-back -> lanes0..3 = 00,01,02,03 then 04..07; ready stays 1.
//  2 x1: frame 0xDDCCBBAA -> lane0 AA,BB,CC,DD on 4 cycles; lanes1-3 00/k=0; ready drops when free < 4.
//  3 SKP_INTERVAL=8, x4 continuous ramp -> after 8 data cycles: BC/k=1 on lanes 0-3, then 3 cycles 1C/k=1;
//    ramp then resumes with no gap or reorder.
//  4 x4, one frame then valid=0 -> one data stripe, then 00/k=0 on all lanes; skp_active_o=0.
//  5 x2 with 6 bytes buffered, rst_ni=0 for 1 cycle -> outputs 0 and count 0 next cycle; stale bytes never appear.
//  6 mask 4'b0101 on enable -> x1 behaviour as in test 2; tx_enable_i=0 mid-stream -> lane_valid_o=0, FIFO empty.

Source files
------------

// File: rtl/pcie_tx_lane_striper_if.sv
// MAC-side frame handshake plus per-lane symbol outputs of the TX lane striper.
interface pcie_tx_lane_striper_if #(
  parameter int MAC_FRAME_WIDTH = 32,
  parameter int NUM_LANES       = 4
);
  localparam int BYTES = MAC_FRAME_WIDTH / 8;

  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i;
  logic [BYTES-1:0]           mac_is_k_i;
  logic                       mac_data_valid_i;
  logic                       mac_data_ready_o;
  logic [NUM_LANES*8-1:0]     lane_data_o;
  logic [NUM_LANES-1:0]       lane_is_k_o;
  logic                       lane_valid_o;
  logic                       skp_active_o;

  modport master (
    output mac_data_frame_i, mac_is_k_i, mac_data_valid_i,
    input  mac_data_ready_o, lane_data_o, lane_is_k_o, lane_valid_o, skp_active_o
  );

  modport slave (
    input  mac_data_frame_i, mac_is_k_i, mac_data_valid_i,
    output mac_data_ready_o, lane_data_o, lane_is_k_o, lane_valid_o, skp_active_o
  );
endinterface

// File: rtl/pcie_tx_lane_striper.sv
// Buffers MAC frames in a byte ring and stripes them across the active lanes,
// interleaving periodic SKP ordered sets on every active lane.
module pcie_tx_lane_striper #(
  parameter int MAC_FRAME_WIDTH = 32,
  parameter int NUM_LANES       = 4,
  parameter int SKP_INTERVAL    = 1180,
  parameter int SKP_LEN         = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_enable_i,
  input  logic [NUM_LANES-1:0] active_lanes_i,
  pcie_tx_lane_striper_if.slave io
);
  localparam int          B     = MAC_FRAME_WIDTH / 8;
  localparam int unsigned DEPTH = 2 * ((B > NUM_LANES) ? B : NUM_LANES);
  localparam int          PTR_W = $clog2(DEPTH);
  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam int          SKC_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int          SYM_W = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;

  localparam logic [CNT_W-1:0]     B_CNT     = CNT_W'(B);
  localparam logic [CNT_W-1:0]     SPACE_LIM = CNT_W'(DEPTH - B);
  localparam logic [SKC_W-1:0]     SKC_LAST  = SKC_W'(SKP_INTERVAL - 1);
  localparam logic [SYM_W-1:0]     SYM_LAST  = SYM_W'(SKP_LEN - 1);
  localparam logic [NUM_LANES-1:0] LANE_ONE  = NUM_LANES'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SKP} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [SKC_W-1:0]       skp_cnt_q, skp_cnt_d;
  logic [SYM_W-1:0]       skp_sym_q, skp_sym_d;
  logic [8:0]             fifo_q [DEPTH];
  logic [8:0]             fifo_d [DEPTH];
  logic [NUM_LANES*8-1:0] lane_data_q, lane_data_d;
  logic [NUM_LANES-1:0]   lane_is_k_q, lane_is_k_d;
  logic                   lane_valid_q, lane_valid_d;
  logic                   skp_active_q, skp_active_d;

  logic                 ready, accept, drain, mask_ok;
  logic [NUM_LANES-1:0] mask_inc;
  logic [CNT_W-1:0]     a_cnt;

  // Ring index arithmetic; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PTR_W'(sum);
  endfunction

  assign ready    = (state_q != ST_IDLE) && (count_q <= SPACE_LIM);
  assign accept   = io.mac_data_valid_i && ready;
  assign drain    = (state_q == ST_RUN) && tx_enable_i && (count_q >= a_cnt);
  assign mask_inc = active_lanes_i + LANE_ONE;
  assign mask_ok  = (|active_lanes_i) && ((active_lanes_i & mask_inc) == '0);

  always_comb begin
    a_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) a_cnt = a_cnt + CNT_W'(mask_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tx_enable_i) state_d = ST_RUN;
      ST_RUN:  if (!tx_enable_i) state_d = ST_IDLE;
               else if (skp_cnt_q == SKC_LAST) state_d = ST_SKP;
      ST_SKP:  if (!tx_enable_i) state_d = ST_IDLE;
               else if (skp_sym_q == SYM_LAST) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_d    = mask_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fifo_d    = fifo_q;
    skp_cnt_d = '0;
    skp_sym_d = '0;
    if (state_q == ST_IDLE && tx_enable_i) mask_d = mask_ok ? active_lanes_i : LANE_ONE;
    // Dropping enable discards everything buffered, including a same-cycle accept.
    if (tx_enable_i) begin
      if (accept) begin
        for (int i = 0; i < B; i++)
          fifo_d[ptr_add(wr_ptr_q, unsigned'(i))] = {io.mac_is_k_i[i], io.mac_data_frame_i[8*i +: 8]};
        wr_ptr_d = ptr_add(wr_ptr_q, unsigned'(B));
      end
      if (drain) rd_ptr_d = ptr_add(rd_ptr_q, 32'(a_cnt));
      count_d = count_q + (accept ? B_CNT : '0) - (drain ? a_cnt : '0);
    end else begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
    if (state_q == ST_RUN && state_d == ST_RUN) skp_cnt_d = skp_cnt_q + SKC_W'(1);
    if (state_q == ST_SKP) skp_cnt_d = skp_cnt_q;
    if (state_q == ST_SKP && state_d == ST_SKP) skp_sym_d = skp_sym_q + SYM_W'(1);
  end

  always_comb begin
    lane_data_d  = '0;
    lane_is_k_d  = '0;
    lane_valid_d = 1'b0;
    skp_active_d = 1'b0;
    if (tx_enable_i && state_q == ST_RUN) begin
      lane_valid_d = 1'b1;
      if (drain) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (mask_q[i]) begin
            lane_data_d[8*i +: 8] = fifo_q[ptr_add(rd_ptr_q, unsigned'(i))][7:0];
            lane_is_k_d[i]        = fifo_q[ptr_add(rd_ptr_q, unsigned'(i))][8];
          end
        end
      end
    end else if (tx_enable_i && state_q == ST_SKP) begin
      lane_valid_d = 1'b1;
      skp_active_d = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mask_q[i]) begin
          lane_data_d[8*i +: 8] = (skp_sym_q == '0) ? 8'hBC : 8'h1C;
          lane_is_k_d[i]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mask_q       <= LANE_ONE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      skp_cnt_q    <= '0;
      skp_sym_q    <= '0;
      lane_data_q  <= '0;
      lane_is_k_q  <= '0;
      lane_valid_q <= 1'b0;
      skp_active_q <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      skp_cnt_q    <= skp_cnt_d;
      skp_sym_q    <= skp_sym_d;
      lane_data_q  <= lane_data_d;
      lane_is_k_q  <= lane_is_k_d;
      lane_valid_q <= lane_valid_d;
      skp_active_q <= skp_active_d;
    end
  end

  // Storage is never read before being written, so it carries no reset.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign io.mac_data_ready_o = ready;
  assign io.lane_data_o      = lane_data_q;
  assign io.lane_is_k_o      = lane_is_k_q;
  assign io.lane_valid_o     = lane_valid_q;
  assign io.skp_active_o     = skp_active_q;
endmodule

// File: tb/tb_pcie_tx_lane_striper.sv
// Scoreboard bench: accepted bytes queue up and are compared stripe by stripe,
// with SKP timing and ready predicted from the lane count and queue occupancy.
module tb_pcie_tx_lane_striper;
  localparam int MW = 32;
  localparam int NL = 4;
  localparam int SI = 8;
  localparam int SL = 4;
  localparam int B  = MW / 8;
  localparam int D  = 2 * ((B > NL) ? B : NL);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_en;
  logic [NL-1:0] mask;

  always #5 clk = ~clk;

  pcie_tx_lane_striper_if #(.MAC_FRAME_WIDTH(MW), .NUM_LANES(NL)) bus ();

  pcie_tx_lane_striper #(
    .MAC_FRAME_WIDTH(MW), .NUM_LANES(NL), .SKP_INTERVAL(SI), .SKP_LEN(SL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_enable_i(tx_en), .active_lanes_i(mask), .io(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  sb [$];   // {k, byte} accepted, not yet striped
  logic [35:0] txq [$];  // {k[3:0], frame} waiting to be offered

  bit          drv_en = 1'b0;
  bit          drv_rst_n = 1'b0;
  logic [3:0]  drv_mask = 4'h1;
  bit          en_d1 = 1'b0, en_d2 = 1'b0;
  bit          pend = 1'b0;
  logic [35:0] pend_frame;
  int          a_model = 1;
  int          run_cnt = 0, skp_pos = 0, cyc = 0;
  int          ramp = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lanes_of(input logic [3:0] m);
    for (int k = 1; k <= NL; k++) if (int'(m) == (1 << k) - 1) return k;
    return 1;
  endfunction

  task automatic tick();
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    logic [8:0]  e;
    bit          exp_v, exp_s, en_eff, rdy_exp, vld;
    @(negedge clk);
    cyc++;
    exp_d = '0; exp_k = '0; exp_v = 1'b0; exp_s = 1'b0;
    if (en_d1 && en_d2) begin
      exp_v = 1'b1;
      if (skp_pos > 0 || run_cnt == SI) begin
        exp_s = 1'b1;
        for (int i = 0; i < a_model; i++) begin
          exp_d[8*i +: 8] = (skp_pos == 0) ? 8'hBC : 8'h1C;
          exp_k[i] = 1'b1;
        end
        skp_pos++;
        if (skp_pos == SL) begin
          skp_pos = 0;
          run_cnt = 0;
        end
      end else begin
        run_cnt++;
        if (sb.size() >= a_model) begin
          for (int i = 0; i < a_model; i++) begin
            e = sb.pop_front();
            exp_d[8*i +: 8] = e[7:0];
            exp_k[i] = e[8];
          end
        end
      end
    end else begin
      run_cnt = 0;
      skp_pos = 0;
    end
    $display("cyc %0d valid=%0d skp=%0d lanes=%h k=%h ready=%0d", cyc, bus.lane_valid_o,
             bus.skp_active_o, bus.lane_data_o, bus.lane_is_k_o, bus.mac_data_ready_o);
    check_eq("lane_valid", 64'(bus.lane_valid_o), 64'(exp_v));
    check_eq("skp_active", 64'(bus.skp_active_o), 64'(exp_s));
    check_eq("lane_data", 64'(bus.lane_data_o), 64'(exp_d));
    check_eq("lane_is_k", 64'(bus.lane_is_k_o), 64'(exp_k));

    if (pend) for (int i = 0; i < B; i++) sb.push_back({pend_frame[32+i], pend_frame[8*i +: 8]});
    rdy_exp = en_d1 && ((D - sb.size()) >= B);
    check_eq("ready", 64'(bus.mac_data_ready_o), 64'(rdy_exp));

    en_eff = drv_en && drv_rst_n;
    rst_n  = drv_rst_n;
    tx_en  = drv_en;
    mask   = drv_mask;
    if (!en_eff) sb.delete();
    if (en_eff && !en_d1) a_model = lanes_of(drv_mask);
    vld = en_eff && (txq.size() > 0);
    bus.mac_data_valid_i = vld;
    bus.mac_data_frame_i = vld ? txq[0][31:0] : 32'h0;
    bus.mac_is_k_i       = vld ? txq[0][35:32] : 4'h0;
    pend = vld && rdy_exp;
    if (pend) pend_frame = txq.pop_front();
    en_d2 = en_d1;
    en_d1 = en_eff;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_drain(input int limit);
    int c = 0;
    while ((txq.size() > 0 || sb.size() > 0 || pend) && c < limit) begin
      tick();
      c++;
    end
    check_eq("drain_bound", 64'(c < limit), 64'(1));
  endtask

  task automatic push_ramp(input int n);
    logic [31:0] f;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < B; i++) f[8*i +: 8] = 8'(ramp + i);
      txq.push_back({4'($urandom_range(0, 15)), f});
      ramp += B;
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_en = 1'b0; mask = 4'h1;
    bus.mac_data_valid_i = 1'b0; bus.mac_data_frame_i = '0; bus.mac_is_k_i = '0;
    run(3);
    drv_rst_n = 1'b1;
    run(2);

    // x4, two back-to-back frames, then a lone frame followed by idle
    drv_mask = 4'hF; drv_en = 1'b1;
    txq.push_back({4'h0, 32'h03020100});
    txq.push_back({4'h0, 32'h07060504});
    wait_drain(40);
    txq.push_back({4'h5, 32'h1C0BBC0A});
    wait_drain(40);
    run(3);
    drv_en = 1'b0; run(2);

    // x1: one frame serialised on lane 0, backpressure from a following burst
    drv_mask = 4'h1; drv_en = 1'b1;
    txq.push_back({4'h0, 32'hDDCCBBAA});
    push_ramp(3);
    wait_drain(80);
    drv_en = 1'b0; run(2);

    // x4 continuous ramp across several SKP insertions
    drv_mask = 4'hF; drv_en = 1'b1;
    push_ramp(16);
    wait_drain(120);
    run(2);
    drv_en = 1'b0; run(2);

    // x2 with bytes buffered, then a one-cycle reset
    drv_mask = 4'h3; drv_en = 1'b1;
    push_ramp(6);
    run(5);
    drv_rst_n = 1'b0; run(1);
    drv_rst_n = 1'b1; txq.delete();
    run(2);
    txq.push_back({4'h3, 32'hA3A2A1A0});
    txq.push_back({4'h0, 32'hA7A6A5A4});
    wait_drain(40);
    drv_en = 1'b0; run(2);

    // non-thermometer mask falls back to x1; enable drops mid-stream
    drv_mask = 4'b0101; drv_en = 1'b1;
    push_ramp(4);
    run(6);
    drv_en = 1'b0; txq.delete(); run(3);
    drv_mask = 4'hF; drv_en = 1'b1;
    run(5);
    drv_en = 1'b0; run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
